// File: rtl/fp_vec3_normalize_folded.sv
// Folded 3-vector normaliser: squares and scales through one shared
// fixed-point multiplier and borrows 1/|v| from an external inverse-sqrt core.
module fp_vec3_normalize_folded #(
    parameter int WIDTH      = 32,
    parameter int FRAC       = 16,
    parameter int EPS_LEN_SQ = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    degen_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic        [WIDTH-1:0] isq_a_out,
    output logic                    isq_valid_out,
    input  logic                    isq_ready_in,
    input  logic        [WIDTH-1:0] isq_res_in,
    input  logic                    isq_valid_in
);

    typedef enum logic [3:0] {
        IDLE, SQ_X, SQ_Y, SQ_Z, ISSUE, WAIT, SC_X, SC_Y, SC_Z, DONE
    } state_t;

    localparam logic [WIDTH-1:0] EPS_W   = WIDTH'(EPS_LEN_SQ);
    localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic        [WIDTH-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] inv_q, inv_d;
    logic signed [WIDTH-1:0] x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
    logic                    degen_q, degen_d;
    logic        [WIDTH-1:0] isq_a_q, isq_a_d;

    logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;
    logic        [WIDTH-1:0] acc_sum;

    // Signed fixed-point multiply with truncation and saturation to WIDTH bits.
    function automatic logic signed [WIDTH-1:0] fp_mul(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] ae, be, p, sh;
        ae = {{WIDTH{a[WIDTH-1]}}, a};
        be = {{WIDTH{b[WIDTH-1]}}, b};
        p  = ae * be;
        sh = p >>> FRAC;
        if (sh[2*WIDTH-1:WIDTH-1] == '0 || sh[2*WIDTH-1:WIDTH-1] == '1)
            fp_mul = sh[WIDTH-1:0];
        else if (sh[2*WIDTH-1])
            fp_mul = {1'b1, {(WIDTH-1){1'b0}}};
        else
            fp_mul = {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // Shared multiplier and saturating accumulate of non-negative squares.
    always_comb begin
        logic [WIDTH-1:0] sum;
        mul_p   = fp_mul(mul_a, mul_b);
        sum     = acc_q + mul_p;
        acc_sum = sum[WIDTH-1] ? ACC_MAX : sum;
    end

    assign ready_out     = (state_q == IDLE);
    assign valid_out     = (state_q == DONE);
    assign isq_valid_out = (state_q == ISSUE) && isq_ready_in;
    assign isq_a_out     = isq_a_q;
    assign x_out         = x_out_q;
    assign y_out         = y_out_q;
    assign z_out         = z_out_q;
    assign degen_out     = degen_q;

    // Next-state, multiplier operand select and datapath updates.
    always_comb begin
        state_d = state_q;
        x_d = x_q;  y_d = y_q;  z_d = z_q;
        acc_d = acc_q;
        inv_d = inv_q;
        x_out_d = x_out_q;  y_out_d = y_out_q;  z_out_d = z_out_q;
        degen_d = degen_q;
        isq_a_d = isq_a_q;
        mul_a = x_q;
        mul_b = x_q;
        case (state_q)
            IDLE: if (valid_in) begin
                x_d = x_in;  y_d = y_in;  z_d = z_in;
                acc_d   = '0;
                state_d = SQ_X;
            end
            SQ_X: begin
                acc_d   = acc_sum;
                state_d = SQ_Y;
            end
            SQ_Y: begin
                mul_a = y_q;  mul_b = y_q;
                acc_d   = acc_sum;
                state_d = SQ_Z;
            end
            SQ_Z: begin
                mul_a = z_q;  mul_b = z_q;
                acc_d = acc_sum;
                if (acc_sum <= EPS_W) begin
                    x_out_d = '0;  y_out_d = '0;  z_out_d = '0;
                    degen_d = 1'b1;
                    state_d = DONE;
                end else begin
                    isq_a_d = acc_sum;
                    state_d = ISSUE;
                end
            end
            ISSUE: if (isq_ready_in) state_d = WAIT;
            WAIT: if (isq_valid_in) begin
                inv_d   = isq_res_in;
                state_d = SC_X;
            end
            SC_X: begin
                mul_b   = inv_q;
                x_out_d = mul_p;
                degen_d = 1'b0;
                state_d = SC_Y;
            end
            SC_Y: begin
                mul_a = y_q;  mul_b = inv_q;
                y_out_d = mul_p;
                state_d = SC_Z;
            end
            SC_Z: begin
                mul_a = z_q;  mul_b = inv_q;
                z_out_d = mul_p;
                state_d = DONE;
            end
            DONE: if (ready_in) begin
                isq_a_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            x_q <= '0;  y_q <= '0;  z_q <= '0;
            acc_q <= '0;
            inv_q <= '0;
            x_out_q <= '0;  y_out_q <= '0;  z_out_q <= '0;
            degen_q <= 1'b0;
            isq_a_q <= '0;
        end else begin
            state_q <= state_d;
            x_q <= x_d;  y_q <= y_d;  z_q <= z_d;
            acc_q <= acc_d;
            inv_q <= inv_d;
            x_out_q <= x_out_d;  y_out_q <= y_out_d;  z_out_q <= z_out_d;
            degen_q <= degen_d;
            isq_a_q <= isq_a_d;
        end
    end

endmodule
